csa_accum_sequencer: RTL and testbench
======================================

// Module: csa_accum_sequencer
// PURPOSE
//  Multi-operand accumulator that sequences one WIDTH-bit 3:2 carry-save stage.
//  Operands stream in over a valid/ready handshake. Each accepted operand is folded
//  into a redundant (sum, carry) pair with no carry propagation. After the last
//  operand, one carry-propagate add resolves the pair. Used to reduce partial-product
//  rows and to accumulate operand batches ahead of the final adder.
// PARAMETERS
//  WIDTH    32  datapath width; all arithmetic is modulo 2^WIDTH
//  MAX_OPS  16  maximum operands per transaction (>=2); CW = $clog2(MAX_OPS+1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operand valid
//  in_ready   out  1      operand accept; a beat transfers when in_valid && in_ready
//  in_data    in   WIDTH  operand
//  in_last    in   1      marks the final operand of a transaction
//  out_valid  out  1      result valid
//  out_ready  in   1      result accept
//  out_data   out  WIDTH  sum of all transaction operands mod 2^WIDTH
//  out_trunc  out  1      transaction was force-closed at MAX_OPS
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; sum, carry, count, out_data, out_valid, out_trunc all 0.
//   rst_n is sampled only on clk. Reset mid-transaction discards all partial state.
//  CSA step: s' = s^c^d; c' = ((s&c)|(s&d)|(c&d)) << 1; the carry MSB shifted out is dropped.
//  States:
//   IDLE:    in_ready=1. On a beat: sum<=in_data, carry<=0, count<=1.
//            in_last=1 -> RESOLVE, else -> ACCUM.
//   ACCUM:   in_ready=1. On a beat: apply the CSA step and count<=count+1.
//            in_last=1 or count+1==MAX_OPS -> RESOLVE.
//            The MAX_OPS close without in_last sets trunc<=1.
//            No beat: hold state; idle gaps are unbounded.
//   RESOLVE: in_ready=0. out_data<=sum+carry (mod 2^WIDTH), out_trunc<=trunc,
//            out_valid<=1 -> DONE.
//   DONE:    in_ready=0. out_valid, out_data and out_trunc are held stable until
//            out_valid && out_ready. On that handshake: out_valid<=0, trunc<=0,
//            count<=0 -> IDLE.
//  Latency: last beat accepted at cycle t -> out_valid=1 at cycle t+2.
//   Next operand is accepted no earlier than the cycle after the output handshake.
//  in_ready is a pure function of state (no combinational path from out_ready).
//  After a MAX_OPS close, the producer's next beat starts a new transaction even if
//   the producer still considers it part of the old one.
//  in_last on an in_valid=0 cycle is ignored.
// CONFIGURATION
//  CSA_SEQ_OPCOUNT_EN defined: adds port out_count (out, CW bits).
//   out_count = operands in the delivered transaction, registered with out_data,
//   held stable in DONE, reset to 0.
//  CSA_SEQ_OPCOUNT_EN undefined: port absent; count is used internally only.
//   All other behaviour is identical.
// TESTING  (WIDTH=32, MAX_OPS=4 unless noted)
//  1,2,3 (last on 3), out_ready=1 -> out_data=6, out_trunc=0, out_valid 2 cycles after 3rd beat
//  Single beat 0xFFFFFFFF with last -> out_data=0xFFFFFFFF; out_count=1 if OPCOUNT_EN
//  0xFFFFFFFF, 0x00000001 (last) -> out_data=0 (wrap); 0x80000000 x2 -> 0 (carry MSB dropped)
//  Operands 5,6 ... hold out_ready=0 for 5 cycles -> out_data=11 stable, in_ready=0, busy=1
//   throughout; handshake -> IDLE, in_ready=1 on the next cycle
//  5 beats of 1, no last -> out_data=4, out_trunc=1; 5th beat opens a new txn -> 1, trunc=0
//  Assert rst_n=0 for 1 cycle after 2 beats -> all outputs 0;
//   then 7 (last) -> out_data=7, not 7+prior

Source files
------------

// File: rtl/csa_accum_sequencer.sv
// Streaming multi-operand accumulator: one 3:2 carry-save stage per accepted beat, one final CPA.
// Optional CSA_SEQ_OPCOUNT_EN adds out_count (operands in the delivered transaction).
module csa_accum_sequencer #(
    parameter int  WIDTH   = 32,
    parameter int  MAX_OPS = 16,
    localparam int CW      = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_trunc,
    output logic             busy
`ifdef CSA_SEQ_OPCOUNT_EN
    ,
    output logic [CW-1:0]    out_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sum, carry, maj;
    logic [CW-1:0]    count, count_inc;
    logic             trunc, beat, at_cap;

    assign beat      = in_valid && in_ready;
    assign count_inc = count + CW'(1);
    assign at_cap    = (count_inc == CW'(MAX_OPS));
    assign maj       = (sum & carry) | (sum & in_data) | (carry & in_data);
    assign busy      = (state != IDLE);

    // in_ready depends on state only, so out_ready never reaches it combinationally
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = in_last ? RESOLVE : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || at_cap)) state_next = RESOLVE;
            end
            RESOLVE: state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum       <= '0;
            carry     <= '0;
            count     <= '0;
            trunc     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_trunc <= 1'b0;
`ifdef CSA_SEQ_OPCOUNT_EN
            out_count <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (beat) begin
                    sum   <= in_data;
                    carry <= '0;
                    count <= CW'(1);
                end
                ACCUM: if (beat) begin
                    // carry MSB falls off the shift: arithmetic is mod 2^WIDTH
                    sum   <= sum ^ carry ^ in_data;
                    carry <= {maj[WIDTH-2:0], 1'b0};
                    count <= count_inc;
                    if (at_cap && !in_last) trunc <= 1'b1;
                end
                RESOLVE: begin
                    out_data  <= sum + carry;
                    out_trunc <= trunc;
                    out_valid <= 1'b1;
`ifdef CSA_SEQ_OPCOUNT_EN
                    out_count <= count;
`endif
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    trunc     <= 1'b0;
                    count     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Directed table-driven bench for csa_accum_sequencer (WIDTH=32, MAX_OPS=4).
module tb_csa_accum_sequencer;

    localparam int WIDTH   = 32;
    localparam int MAX_OPS = 4;
    localparam int CW      = $clog2(MAX_OPS + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_last;
    logic [WIDTH-1:0] in_data;
    logic             out_valid, out_ready, out_trunc, busy;
    logic [WIDTH-1:0] out_data;
`ifdef CSA_SEQ_OPCOUNT_EN
    logic [CW-1:0]    out_count;
`endif

    csa_accum_sequencer #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_trunc(out_trunc), .busy(busy)
`ifdef CSA_SEQ_OPCOUNT_EN
        , .out_count(out_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][31:0] ops;
        int               n;
        logic             last;   // in_last on the final beat
        int               gap;    // idle cycles between beats
        int               hold;   // cycles out_ready stays low in DONE
        logic [31:0]      exp_data;
        logic             exp_trunc;
    } vec_t;

    vec_t tbl[9];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int cnt;
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            in_data  = v.ops[i];
            in_last  = v.last && (i == v.n - 1);
            chk("in_ready_beat", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b1;  // must be ignored while in_valid=0
            for (int g = 0; g < v.gap && i < v.n - 1; g++) tick();
            in_last  = 1'b0;
        end
        cnt = 0;
        while (!out_valid && cnt < 8) begin
            tick();
            cnt++;
        end
        chk("latency", 32'(cnt), 32'd1);
        chk("out_data", out_data, v.exp_data);
        chk("out_trunc", 32'(out_trunc), 32'(v.exp_trunc));
`ifdef CSA_SEQ_OPCOUNT_EN
        chk("out_count", 32'(out_count), 32'(v.n));
`endif
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, v.exp_data);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        // ops packed MSB-first: ops[0] is the rightmost element
        tbl[0] = '{ops: {32'd0, 32'd3, 32'd2, 32'd1}, n: 3, last: 1'b1, gap: 0, hold: 0,
                   exp_data: 32'd6, exp_trunc: 1'b0};
        tbl[1] = '{ops: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, n: 1, last: 1'b1, gap: 0, hold: 0,
                   exp_data: 32'hFFFF_FFFF, exp_trunc: 1'b0};
        tbl[2] = '{ops: {32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, n: 2, last: 1'b1, gap: 0, hold: 0,
                   exp_data: 32'd0, exp_trunc: 1'b0};
        tbl[3] = '{ops: {32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000}, n: 2, last: 1'b1, gap: 0,
                   hold: 0, exp_data: 32'd0, exp_trunc: 1'b0};
        tbl[4] = '{ops: {32'd0, 32'd0, 32'd6, 32'd5}, n: 2, last: 1'b1, gap: 0, hold: 5,
                   exp_data: 32'd11, exp_trunc: 1'b0};
        tbl[5] = '{ops: {32'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h1234_5678}, n: 3, last: 1'b1,
                   gap: 3, hold: 1, exp_data: 32'h1234_5677, exp_trunc: 1'b0};
        tbl[6] = '{ops: {32'd40, 32'd30, 32'd20, 32'd10}, n: 4, last: 1'b1, gap: 1, hold: 0,
                   exp_data: 32'd100, exp_trunc: 1'b0};
        // 5 beats of 1 without last: capped at 4, the 5th opens a new transaction
        tbl[7] = '{ops: {32'd1, 32'd1, 32'd1, 32'd1}, n: 4, last: 1'b0, gap: 0, hold: 0,
                   exp_data: 32'd4, exp_trunc: 1'b1};
        tbl[8] = '{ops: {32'd0, 32'd0, 32'd0, 32'd1}, n: 1, last: 1'b1, gap: 0, hold: 0,
                   exp_data: 32'd1, exp_trunc: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_trunc", 32'(out_trunc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 9; k++) run_txn(tbl[k]);

        // Non-zero output registers so the mid-transaction reset has something to clear
        v = '{ops: {32'd0, 32'd0, 32'd0, 32'd9}, n: 1, last: 1'b1, gap: 0, hold: 0,
              exp_data: 32'd9, exp_trunc: 1'b0};
        run_txn(v);
        in_valid = 1'b1; in_data = 32'd100; in_last = 1'b0;
        tick();
        in_data = 32'd200;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_trunc", 32'(out_trunc), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef CSA_SEQ_OPCOUNT_EN
        chk("mid_rst_out_count", 32'(out_count), 32'd0);
`endif
        v = '{ops: {32'd0, 32'd0, 32'd0, 32'd7}, n: 1, last: 1'b1, gap: 0, hold: 0,
              exp_data: 32'd7, exp_trunc: 1'b0};
        run_txn(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
